ofmap_output_controller: RTL and testbench
==========================================

# ofmap_output_controller

Drains the ofmap double buffer's read bank to the external output stream, acting as the responder to the main FSM's ofmap switch/start handshake. It owns the read-bank select, issues one-cycle-latency SRAM reads, and buffers returned words in a 2-entry skid FIFO so that downstream backpressure never drops data. When the read bank is fully drained, it raises `ofmap_read_bank_ready_to_switch` so the main FSM can leave its post-MAC wait state.

## Interface
- `DATA_WIDTH`, default 16: width of one ofmap word.
- `BANK_ADDR_WIDTH`, default 8: address width of one ofmap bank (depth up to 2^BANK_ADDR_WIDTH).

Ports:
- `clk` input, 1: clock.
- `rst_n` input, 1: reset, synchronous, active-low.
- `config_en` input, 1: latch `config_bank_depth`. Honoured only in IDLE.
- `config_bank_depth` input, BANK_ADDR_WIDTH+1: number of words to drain per bank, 0..2^BANK_ADDR_WIDTH.
- `ofmap_ready_to_switch` input, 1: single-cycle pulse from the main FSM that toggles the read bank.
- `ofmap_start_new_read_bank` input, 1: single-cycle pulse from the main FSM that starts draining the current read bank.
- `ofmap_read_bank_ready_to_switch` output, 1: high when idle, i.e. the read bank is drained.
- `read_bank_sel` output, 1: selects the read bank of the double buffer. The write bank is its complement.
- `ofmap_ren` output, 1: SRAM read enable.
- `ofmap_raddr` output, BANK_ADDR_WIDTH: SRAM read address.
- `ofmap_rdata` input, DATA_WIDTH: SRAM read data, valid on the cycle after `ofmap_ren`.
- `ofmap_dat` output, DATA_WIDTH: output stream data.
- `ofmap_vld` output, 1: output stream valid.
- `ofmap_rdy` input, 1: output stream ready.

## Operation
- **States:**
  - IDLE: initial state.
  - READ: reads are being issued.
  - DRAIN: all reads issued; waiting for the FIFO and any in-flight read to empty.
- **IDLE:**
  - `ofmap_ready_to_switch` toggles `read_bank_sel`. The pulse is ignored outside IDLE.
  - `ofmap_start_new_read_bank` with latched depth > 0: clear the address counter and go to READ.
  - `ofmap_start_new_read_bank` with latched depth == 0: remain in IDLE.
  - Start outside IDLE is ignored.
- **READ:**
  - Let `pending` = FIFO occupancy + in-flight reads (0/1) − pop this cycle.
  - Issue `ofmap_ren` with `ofmap_raddr` = counter when `pending` < 2, then increment the counter.
  - On issuing address depth−1, go to DRAIN.
- **DRAIN:** when the FIFO is empty and no read is in flight, go to IDLE.
- **FIFO:**
  - Depth 2.
  - Push `ofmap_rdata` on the cycle after each `ofmap_ren`.
  - `ofmap_vld` = FIFO not empty. `ofmap_dat` = FIFO head.
  - Pop on `ofmap_vld & ofmap_rdy`.
  - By construction the FIFO never overflows; pushing into a full FIFO is a design bug and an assertion target.
- **Outputs:** `ofmap_read_bank_ready_to_switch` = (state == IDLE). It is a registered-state decode with no combinational path from inputs.
- **Simultaneous switch and start in IDLE:** both are honoured. The first read uses the new bank, because `read_bank_sel` updates at the same edge that READ is entered.
- **Address counter:** counts 0..depth−1 and never wraps inside a bank. With depth = 2^BANK_ADDR_WIDTH, the last address is all-ones.

## Timing
- **Reset values:**
  - state IDLE, `read_bank_sel` 0, FIFO empty, counter 0, latched depth 0.
  - `ofmap_read_bank_ready_to_switch` 1, `ofmap_ren` 0, `ofmap_raddr` 0, `ofmap_vld` 0, `ofmap_dat` 0.
- **Start latency:** start pulse at cycle T gives READ at T+1, `ofmap_ren` (addr 0) at T+1, data pushed at T+2, and `ofmap_vld` at T+3.
- **Throughput:** with `ofmap_rdy` held high, one word per cycle. N words complete on cycles T+3..T+N+2.
- **Return to IDLE:** `ofmap_read_bank_ready_to_switch` rises on the cycle after the last word's handshake.
- **Reset mid-operation:** reset returns all state to reset values. The FIFO is flushed and any in-flight read data is discarded.
- **Stream rule:** while `ofmap_vld` is high and `ofmap_rdy` is low, `ofmap_dat` holds stable.

## Configuration
- `OFMAP_OUT_LAST_EN`:
  - Defined: adds output `ofmap_last` (1 bit, reset 0), high together with `ofmap_vld` on the final word of each bank. A per-entry flag bit is stored in the FIFO.
  - Undefined: the port and the flag storage are absent, and behaviour is otherwise identical.

## Test plan
- **Basic drain:** depth=4, bank 0 preloaded with 10,11,12,13, start pulse, `ofmap_rdy`=1.
  - Words 10..13 appear on consecutive cycles T+3..T+6.
  - `ofmap_read_bank_ready_to_switch` is 0 during T+1..T+6 and 1 at T+7.
- **Backpressure:** depth=8, `ofmap_rdy` toggled 1,0,0,1,…
  - All 8 words are delivered in order with no loss or duplication.
  - `ofmap_dat` is stable during stalls.
  - `ofmap_ren` is never issued when `pending` == 2.
- **Bank switch:** switch+start in the same cycle with bank 1 = 0x20..0x23.
  - `read_bank_sel` = 1 at T+1 and output is 0x20..0x23.
  - A second switch pulse in READ leaves `read_bank_sel` unchanged.
- **Depth boundaries:**
  - depth=0: start causes no `ofmap_ren` and ready stays 1.
  - depth=256 (`BANK_ADDR_WIDTH`=8): the last address is 0xFF and exactly 256 words are delivered.
- **Reset mid-drain:** `rst_n`=0 at the third word of depth=8.
  - All outputs return to reset values the next cycle.
  - A new start replays from address 0.
- **`OFMAP_OUT_LAST_EN`:** depth=3.
  - `ofmap_last` is high only with the third word, including when that word is stalled for 2 cycles.

Source files
------------

// File: rtl/ofmap_output_controller.sv
// ofmap_output_controller
// Drains the read bank of the ofmap double buffer to the output stream.
// Owns the read-bank select, issues one-cycle-latency SRAM reads and keeps
// returned words in a 2-entry skid FIFO so backpressure never loses data.
// Optional feature: define OFMAP_OUT_LAST_EN to add the ofmap_last output,
// flagging the final word of each bank.
module ofmap_output_controller #(
  parameter int DATA_WIDTH      = 16,
  parameter int BANK_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_en,
  input  logic [BANK_ADDR_WIDTH:0]   config_bank_depth,
  input  logic                       ofmap_ready_to_switch,
  input  logic                       ofmap_start_new_read_bank,
  output logic                       ofmap_read_bank_ready_to_switch,
  output logic                       read_bank_sel,
  output logic                       ofmap_ren,
  output logic [BANK_ADDR_WIDTH-1:0] ofmap_raddr,
  input  logic [DATA_WIDTH-1:0]      ofmap_rdata,
  output logic [DATA_WIDTH-1:0]      ofmap_dat,
  output logic                       ofmap_vld,
`ifdef OFMAP_OUT_LAST_EN
  output logic                       ofmap_last,
`endif
  input  logic                       ofmap_rdy
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_e;

  localparam logic [BANK_ADDR_WIDTH:0]   DEPTH_ONE = 1;
  localparam logic [BANK_ADDR_WIDTH-1:0] ADDR_ONE  = 1;

  state_e                     state_q, state_d;
  logic                       sel_q, sel_d;
  logic [BANK_ADDR_WIDTH:0]   depth_q, depth_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                       infl_q, infl_d;

  logic [DATA_WIDTH-1:0]      mem_q [2];
  logic [DATA_WIDTH-1:0]      mem_d [2];
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 count_q, count_d;

  logic                       push;
  logic                       pop;
  logic [2:0]                 pending;
  logic                       last_issue;

  // Returned data lands one cycle after the read, so the in-flight flag is the push.
  assign push       = infl_q;
  assign ofmap_vld  = (count_q != 2'd0);
  assign pop        = ofmap_vld && ofmap_rdy;
  assign ofmap_dat  = ofmap_vld ? mem_q[rd_ptr_q] : '0;
  // Words already owed to the FIFO after this cycle's pop; a new read must fit.
  assign pending    = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign last_issue = ({1'b0, cnt_q} == (depth_q - DEPTH_ONE));

  assign ofmap_ren                       = (state_q == ST_READ) && (pending < 3'd2);
  assign ofmap_raddr                     = cnt_q;
  assign read_bank_sel                   = sel_q;
  assign ofmap_read_bank_ready_to_switch = (state_q == ST_IDLE);

  // Skid FIFO next-state: write on push, advance head on pop.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = ofmap_rdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Control FSM next-state: bank select, depth latch, address counter.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    infl_d  = ofmap_ren;
    unique case (state_q)
      ST_IDLE: begin
        if (config_en) depth_d = config_bank_depth;
        if (ofmap_ready_to_switch) sel_d = ~sel_q;
        if (ofmap_start_new_read_bank && (depth_q != '0)) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (ofmap_ren) begin
          // Hold on the final address so the counter never wraps inside a bank.
          if (last_issue) state_d = ST_DRAIN;
          else            cnt_d   = cnt_q + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        if ((count_d == 2'd0) && !infl_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      depth_q  <= '0;
      cnt_q    <= '0;
      infl_q   <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      depth_q  <= depth_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observed through ofmap_vld-qualified reads.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; the reset count/pointers make stale entries invisible.
    mem_q <= mem_d;
  end

`ifdef OFMAP_OUT_LAST_EN
  logic last_mem_q [2];
  logic last_mem_d [2];
  logic infl_last_q, infl_last_d;

  // Per-entry last flag travels with its word through the FIFO.
  always_comb begin
    last_mem_d  = last_mem_q;
    infl_last_d = ofmap_ren && last_issue;
    if (push) last_mem_d[wr_ptr_q] = infl_last_q;
  end

  // In-flight last flag is control state and is reset; the flag array is not.
  always_ff @(posedge clk) begin
    if (!rst_n) infl_last_q <= 1'b0;
    else        infl_last_q <= infl_last_d;
    last_mem_q <= last_mem_d;
  end

  assign ofmap_last = ofmap_vld && last_mem_q[rd_ptr_q];
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_ofmap_output_controller.sv
// Self-checking bench for ofmap_output_controller: a behavioural SRAM model,
// an expected-word queue per bank drain and per-cycle protocol checks.
`timescale 1ns/1ps
module tb_ofmap_output_controller;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          config_en = 1'b0;
  logic [AW:0]   config_bank_depth = '0;
  logic          sw = 1'b0;
  logic          start = 1'b0;
  logic          ready_out;
  logic          read_bank_sel;
  logic          ofmap_ren;
  logic [AW-1:0] ofmap_raddr;
  logic [DW-1:0] ofmap_rdata = '0;
  logic [DW-1:0] ofmap_dat;
  logic          ofmap_vld;
  logic          ofmap_rdy = 1'b0;
`ifdef OFMAP_OUT_LAST_EN
  logic          ofmap_last;
`endif

  logic [DW-1:0] bank_mem [2][256];
  bit            model_sel = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ofmap_output_controller #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .config_en                       (config_en),
    .config_bank_depth               (config_bank_depth),
    .ofmap_ready_to_switch           (sw),
    .ofmap_start_new_read_bank       (start),
    .ofmap_read_bank_ready_to_switch (ready_out),
    .read_bank_sel                   (read_bank_sel),
    .ofmap_ren                       (ofmap_ren),
    .ofmap_raddr                     (ofmap_raddr),
    .ofmap_rdata                     (ofmap_rdata),
    .ofmap_dat                       (ofmap_dat),
    .ofmap_vld                       (ofmap_vld),
`ifdef OFMAP_OUT_LAST_EN
    .ofmap_last                      (ofmap_last),
`endif
    .ofmap_rdy                       (ofmap_rdy)
  );

  // SRAM model: data for a read appears on the following cycle.
  always @(posedge clk) begin
    if (ofmap_ren) ofmap_rdata <= bank_mem[read_bank_sel][ofmap_raddr];
  end

  task automatic cfg(input int depth);
    @(negedge clk);
    config_en = 1'b1;
    config_bank_depth = depth[AW:0];
    @(negedge clk);
    config_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ready_out !== 1'b1 || ofmap_ren !== 1'b0 || ofmap_raddr !== '0 ||
        ofmap_vld !== 1'b0 || ofmap_dat !== '0 || read_bank_sel !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy_sw=%b ren=%b raddr=%0h vld=%b dat=%0h sel=%b, want 1 0 0 0 0 0",
               name, ready_out, ofmap_ren, ofmap_raddr, ofmap_vld, ofmap_dat, read_bank_sel);
    end
`ifdef OFMAP_OUT_LAST_EN
    checks++;
    if (ofmap_last !== 1'b0) begin
      errors++;
      $display("FAIL %s last: got %b want 0", name, ofmap_last);
    end
`endif
  endtask

  // One full bank drain. rdy_mode: 0 always ready, 1 pattern 1,0,0,1,
  // 2 random, 3 stall the final word twice. sw_mid pulses a switch on that cycle.
  task automatic run_drain(input string name, input int depth, input int rdy_mode,
                           input bit sw_start, input int sw_mid);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_dat;
    int issued, delivered, last_hs, budget, max_addr, stall_n, c, pend;
    bit prev_stall, done, pop;

    cfg(depth);
    @(negedge clk);
    start = 1'b1;
    sw = sw_start;
    ofmap_rdy = 1'b1;
    if (sw_start) model_sel = ~model_sel;
    for (int i = 0; i < depth; i++) exp_q.push_back(bank_mem[model_sel][i]);

    issued = 0; delivered = 0; last_hs = -1; max_addr = -1; stall_n = 0;
    prev_stall = 1'b0; prev_dat = '0; done = 1'b0;
    budget = depth * 6 + 20;
    c = 1;
    while (c <= budget && !done) begin
      @(negedge clk);
      start = 1'b0;
      sw = (c == sw_mid);
      case (rdy_mode)
        0: ofmap_rdy = 1'b1;
        1: ofmap_rdy = ((c % 4) == 0) || ((c % 4) == 3);
        2: ofmap_rdy = 1'($urandom_range(0, 1));
        default: begin
          if (ofmap_vld && exp_q.size() == 1 && stall_n < 2) begin
            ofmap_rdy = 1'b0;
            stall_n++;
          end else begin
            ofmap_rdy = 1'b1;
          end
        end
      endcase
      #1;
      pop = ofmap_vld && ofmap_rdy;

      checks++;
      if (read_bank_sel !== model_sel) begin
        errors++;
        $display("FAIL %s sel c=%0d: got %b want %b", name, c, read_bank_sel, model_sel);
      end

      if (delivered < depth) begin
        checks++;
        if (ready_out !== 1'b0) begin
          errors++;
          $display("FAIL %s busy c=%0d: ready_to_switch got %b want 0", name, c, ready_out);
        end
      end else begin
        checks++;
        if (ready_out !== 1'b1 || c != last_hs + 1) begin
          errors++;
          $display("FAIL %s idle c=%0d: ready_to_switch got %b want 1 at c=%0d", name, c, ready_out, last_hs + 1);
        end
        done = 1'b1;
      end

      if (ofmap_ren) begin
        pend = issued - delivered - int'(pop);
        checks++;
        if (issued >= depth) begin
          errors++;
          $display("FAIL %s extra read c=%0d: got ren=1 want 0", name, c);
        end
        checks++;
        if (ofmap_raddr !== issued[AW-1:0]) begin
          errors++;
          $display("FAIL %s raddr c=%0d: got %0h want %0h", name, c, ofmap_raddr, issued[AW-1:0]);
        end
        checks++;
        if (pend >= 2) begin
          errors++;
          $display("FAIL %s pending c=%0d: got ren with pending=%0d want <2", name, c, pend);
        end
        if (rdy_mode == 0) begin
          checks++;
          if (c != issued + 1) begin
            errors++;
            $display("FAIL %s ren timing: got c=%0d want c=%0d", name, c, issued + 1);
          end
        end
        max_addr = int'(ofmap_raddr);
        issued++;
      end

      if (ofmap_vld && prev_stall) begin
        checks++;
        if (ofmap_dat !== prev_dat) begin
          errors++;
          $display("FAIL %s stall hold c=%0d: got %0h want %0h", name, c, ofmap_dat, prev_dat);
        end
      end
`ifdef OFMAP_OUT_LAST_EN
      checks++;
      if (ofmap_last !== (ofmap_vld && exp_q.size() == 1)) begin
        errors++;
        $display("FAIL %s last c=%0d: got %b want %b", name, c, ofmap_last, ofmap_vld && exp_q.size() == 1);
      end
`endif
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra word c=%0d: got %0h want none", name, c, ofmap_dat);
        end else begin
          if (ofmap_dat !== exp_q[0]) begin
            errors++;
            $display("FAIL %s data #%0d: got %0h want %0h", name, delivered, ofmap_dat, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        delivered++;
        last_hs = c;
        if (rdy_mode == 0) begin
          checks++;
          if (c != delivered + 2) begin
            errors++;
            $display("FAIL %s word timing: got c=%0d want c=%0d", name, c, delivered + 2);
          end
        end
      end
      prev_stall = ofmap_vld && !ofmap_rdy;
      prev_dat = ofmap_dat;
      c++;
    end

    checks++;
    if (!done || delivered != depth) begin
      errors++;
      $display("FAIL %s completion: got %0d words done=%b want %0d words done=1", name, delivered, done, depth);
    end
    checks++;
    if (max_addr != depth - 1) begin
      errors++;
      $display("FAIL %s last addr: got %0h want %0h", name, max_addr, depth - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("after reset");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) bank_mem[0][i] = DW'(10 + i);
    run_drain("basic", 4, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_drain("backpressure", 8, 1, 1'b0, 0);
  endtask

  task automatic test_bank_switch();
    for (int i = 0; i < 4; i++) bank_mem[1][i] = DW'(32'h20 + i);
    run_drain("bank switch", 4, 0, 1'b1, 2);
  endtask

  task automatic test_depth_zero();
    cfg(0);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (ofmap_ren !== 1'b0 || ready_out !== 1'b1) begin
        errors++;
        $display("FAIL depth0 c=%0d: got ren=%b ready=%b want 0 1", c, ofmap_ren, ready_out);
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_depth_full();
    run_drain("depth256", 256, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_drain();
    int hs;
    bit hit;
    hs = 0;
    hit = 1'b0;
    cfg(8);
    @(negedge clk);
    start = 1'b1;
    ofmap_rdy = 1'b1;
    for (int c = 1; c <= 20 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ofmap_vld && hs == 2) begin
        rst_n = 1'b0;
        hit = 1'b1;
      end else if (ofmap_vld && ofmap_rdy) begin
        hs++;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset mid: got %0d handshakes want third word present", hs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_sel = 1'b0;
    #1;
    check_reset_outputs("reset mid");
    run_drain("replay", 8, 0, 1'b0, 0);
  endtask

  task automatic test_last();
    run_drain("last", 3, 3, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_drain("random", $urandom_range(1, 24), 2, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) bank_mem[b][i] = DW'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_bank_switch();
    test_depth_zero();
    test_depth_full();
    test_reset_mid_drain();
    test_last();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
